// File: rtl/pe_stream_driver_pkg.sv
// Shared constants, state encoding and cfg field helpers for the PE stream driver.
package pe_stream_driver_pkg;

  localparam int CFG_BITS        = 10;
  localparam int Q_LSB           = 0;
  localparam int F_LSB           = 2;
  localparam int P_LSB           = 7;
  localparam int MODE_BIT        = 9;
  localparam int DEF_FILT_BEATS  = 12;
  localparam int DEF_IFMAP_BEATS = 3;
  localparam int CNT_BITS        = 5;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE = 3'd0;
  localparam state_t S_CFG  = 3'd1;
  localparam state_t S_FILT = 3'd2;
  localparam state_t S_IFM0 = 3'd3;
  localparam state_t S_IPS  = 3'd4;
  localparam state_t S_OPS  = 3'd5;
  localparam state_t S_IFM1 = 3'd6;
  localparam state_t S_DONE = 3'd7;

  function automatic logic [1:0] cfg_p(input logic [CFG_BITS-1:0] cfg);
    return cfg[P_LSB +: 2];
  endfunction

  function automatic logic [4:0] cfg_f(input logic [CFG_BITS-1:0] cfg);
    return cfg[F_LSB +: 5];
  endfunction

  function automatic logic [1:0] cfg_q(input logic [CFG_BITS-1:0] cfg);
    return cfg[Q_LSB +: 2];
  endfunction

  function automatic logic cfg_mode(input logic [CFG_BITS-1:0] cfg);
    return cfg[MODE_BIT];
  endfunction

endpackage

// File: rtl/pe_stream_driver_if.sv
// PE stream and SRAM port bundle; master is the driver, slave is the PE/SRAM side.
interface pe_stream_driver_if #(
  parameter int DATA_BITS = 32,
  parameter int ADDR_BITS = 12
);
  logic                 mem_re;
  logic [ADDR_BITS-1:0] mem_raddr;
  logic [DATA_BITS-1:0] mem_rdata;
  logic                 mem_we;
  logic [ADDR_BITS-1:0] mem_waddr;
  logic [DATA_BITS-1:0] mem_wdata;
  logic                 PE_en;
  logic [9:0]           i_config;
  logic [DATA_BITS-1:0] filter, ifmap, ipsum, opsum;
  logic                 filter_valid, ifmap_valid, ipsum_valid, opsum_valid;
  logic                 filter_ready, ifmap_ready, ipsum_ready, opsum_ready;

  modport master (
    output mem_re, mem_raddr, mem_we, mem_waddr, mem_wdata, PE_en, i_config,
    output filter, ifmap, ipsum, filter_valid, ifmap_valid, ipsum_valid, opsum_ready,
    input  mem_rdata, filter_ready, ifmap_ready, ipsum_ready, opsum, opsum_valid
  );

  modport slave (
    input  mem_re, mem_raddr, mem_we, mem_waddr, mem_wdata, PE_en, i_config,
    input  filter, ifmap, ipsum, filter_valid, ifmap_valid, ipsum_valid, opsum_ready,
    output mem_rdata, filter_ready, ifmap_ready, ipsum_ready, opsum, opsum_valid
  );
endinterface

// File: rtl/pe_stream_driver_beat_fetch.sv
// Burst reader: issues SRAM reads for a counted run of words and presents them as a
// valid/ready stream through a 2-entry prefetch buffer.
module pe_beat_fetch
  import pe_stream_driver_pkg::*;
#(
  parameter int DATA_BITS = 32,
  parameter int ADDR_BITS = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 go,
  input  logic [ADDR_BITS-1:0] base,
  input  logic [CNT_BITS-1:0]  count,
  output logic                 mem_re,
  output logic [ADDR_BITS-1:0] mem_raddr,
  input  logic [DATA_BITS-1:0] mem_rdata,
  output logic                 valid,
  output logic [DATA_BITS-1:0] data,
  input  logic                 ready,
  output logic                 last
);

  logic [ADDR_BITS-1:0] rd_addr;
  logic [CNT_BITS-1:0]  issue_left, beats_left;
  logic                 in_flight;
  logic [DATA_BITS-1:0] buf_q [2];
  logic                 wr_ptr, rd_ptr;
  logic [1:0]           buf_cnt, occ;
  logic                 pop;

  assign valid = (buf_cnt != 2'd0);
  assign pop   = valid && ready;
  assign data  = buf_q[rd_ptr];
  assign last  = (beats_left == CNT_BITS'(1));

  // Occupancy after this cycle's pop; a read may go out whenever a slot stays free,
  // which keeps one beat per cycle flowing without ever overrunning the buffer.
  assign occ       = buf_cnt + {1'b0, in_flight} - {1'b0, pop};
  assign mem_re    = (issue_left != '0) && (occ < 2'd2);
  assign mem_raddr = mem_re ? rd_addr : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_addr    <= '0;
      issue_left <= '0;
      beats_left <= '0;
      in_flight  <= 1'b0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      buf_cnt    <= 2'd0;
      buf_q[0]   <= '0;
      buf_q[1]   <= '0;
    end else begin
      if (go) begin
        rd_addr    <= base;
        issue_left <= count;
        beats_left <= count;
      end else begin
        if (mem_re) begin
          rd_addr    <= rd_addr + 1'b1;
          issue_left <= issue_left - 1'b1;
        end
        if (pop)
          beats_left <= beats_left - 1'b1;
      end
      in_flight <= mem_re;
      if (in_flight) begin
        buf_q[wr_ptr] <= mem_rdata;
        wr_ptr        <= ~wr_ptr;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
      buf_cnt <= occ;
    end
  end

endmodule

// File: rtl/pe_stream_driver.sv
// Sequences one PE pass: config strobe, filter/ifmap/ipsum fetch streams and opsum write-back.
module pe_stream_driver
  import pe_stream_driver_pkg::*;
#(
  parameter int DATA_BITS   = 32,
  parameter int ADDR_BITS   = 12,
  parameter int FILT_BEATS  = DEF_FILT_BEATS,
  parameter int IFMAP_BEATS = DEF_IFMAP_BEATS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CFG_BITS-1:0]  cfg,
  input  logic [ADDR_BITS-1:0] filter_base,
  input  logic [ADDR_BITS-1:0] ifmap_base,
  input  logic [ADDR_BITS-1:0] ipsum_base,
  input  logic [ADDR_BITS-1:0] opsum_base,
  output logic                 busy,
  output logic                 done,
  pe_stream_driver_if.master   bus
);

  state_t               state, state_nxt;
  logic [1:0]           p, opk;
  logic [4:0]           f, o;
  logic [CNT_BITS-1:0]  grp_beats;
  logic [ADDR_BITS-1:0] grp, ifm_addr;
  logic                 go, f_valid, f_ready, f_last, fire, op_fire, op_last;
  logic [ADDR_BITS-1:0] go_base;
  logic [CNT_BITS-1:0]  go_count;
  logic [DATA_BITS-1:0] f_data;

  assign p         = cfg_p(cfg);
  assign f         = cfg_f(cfg);
  assign grp_beats = CNT_BITS'(p) + CNT_BITS'(1);
  assign fire      = f_valid && f_ready;
  assign op_fire   = bus.opsum_valid && (state == S_OPS);
  assign op_last   = (opk == p);

  pe_beat_fetch #(.DATA_BITS(DATA_BITS), .ADDR_BITS(ADDR_BITS)) u_fetch (
    .clk       (clk),
    .rst       (rst),
    .go        (go),
    .base      (go_base),
    .count     (go_count),
    .mem_re    (bus.mem_re),
    .mem_raddr (bus.mem_raddr),
    .mem_rdata (bus.mem_rdata),
    .valid     (f_valid),
    .data      (f_data),
    .ready     (f_ready),
    .last      (f_last)
  );

  always_comb begin
    f_ready = 1'b0;
    case (state)
      S_FILT:         f_ready = bus.filter_ready;
      S_IFM0, S_IFM1: f_ready = bus.ifmap_ready;
      S_IPS:          f_ready = bus.ipsum_ready;
      default:        f_ready = 1'b0;
    endcase
  end

  // Each read state is armed by a go pulse in the cycle that enters it, so the
  // fetcher is always loaded exactly when its previous burst has fully drained.
  always_comb begin
    state_nxt = state;
    go        = 1'b0;
    go_base   = filter_base;
    go_count  = CNT_BITS'(FILT_BEATS);
    case (state)
      S_IDLE: if (start) state_nxt = S_CFG;
      S_CFG: begin
        go        = 1'b1;
        state_nxt = S_FILT;
      end
      S_FILT: if (fire && f_last) begin
        go        = 1'b1;
        go_base   = ifm_addr;
        go_count  = CNT_BITS'(IFMAP_BEATS);
        state_nxt = S_IFM0;
      end
      S_IFM0, S_IFM1: if (fire && f_last) begin
        go        = 1'b1;
        go_base   = ipsum_base + grp;
        go_count  = grp_beats;
        state_nxt = S_IPS;
      end
      S_IPS: if (fire && f_last) state_nxt = S_OPS;
      S_OPS: if (op_fire && op_last) begin
        if (o == f) begin
          state_nxt = S_DONE;
        end else begin
          go        = 1'b1;
          go_base   = ifm_addr;
          go_count  = CNT_BITS'(1);
          state_nxt = S_IFM1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // grp tracks o*(p+1) by accumulation; ifm_addr walks the ifmap words in order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      o        <= '0;
      opk      <= '0;
      grp      <= '0;
      ifm_addr <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_CFG) begin
        o        <= '0;
        opk      <= '0;
        grp      <= '0;
        ifm_addr <= ifmap_base;
      end
      if (fire && (state == S_IFM0 || state == S_IFM1))
        ifm_addr <= ifm_addr + 1'b1;
      if (op_fire) begin
        if (op_last) begin
          opk <= '0;
          if (o != f) begin
            o   <= o + 1'b1;
            grp <= grp + ADDR_BITS'(grp_beats);
          end
        end else begin
          opk <= opk + 1'b1;
        end
      end
    end
  end

  assign bus.filter_valid = f_valid && (state == S_FILT);
  assign bus.ifmap_valid  = f_valid && (state == S_IFM0 || state == S_IFM1);
  assign bus.ipsum_valid  = f_valid && (state == S_IPS);
  assign bus.filter       = (state == S_FILT) ? f_data : '0;
  assign bus.ifmap        = (state == S_IFM0 || state == S_IFM1) ? f_data : '0;
  assign bus.ipsum        = (state == S_IPS) ? f_data : '0;
  assign bus.PE_en        = (state == S_CFG);
  assign bus.i_config     = cfg;
  assign bus.opsum_ready  = (state == S_OPS);
  assign bus.mem_we       = op_fire;
  assign bus.mem_waddr    = op_fire ? (opsum_base + grp + ADDR_BITS'(opk)) : '0;
  assign bus.mem_wdata    = op_fire ? bus.opsum : '0;
  assign busy             = (state != S_IDLE) && (state != S_DONE);
  assign done             = (state == S_DONE);

endmodule
